// File: rtl/apb_gpio_pkg.sv
// Shared types and width helpers for the multi-channel APB-to-GPIO bridge.
package apb_gpio_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Index width that never collapses to zero bits for single-entry ranges.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned ch_w(input int unsigned num_ch);
    return clog2_min1(num_ch);
  endfunction

  function automatic int unsigned to_w(input int unsigned timeout);
    return clog2_min1(timeout);
  endfunction

endpackage

// File: rtl/apb_gpio_bridge_mc_if.sv
// APB3 bus bundle between the system fabric (master) and the bridge (slave).
interface apb_gpio_bridge_mc_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 16
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic              pready;
  logic              pslverr;
  logic [DATA_W-1:0] prdata;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  pready, pslverr, prdata
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output pready, pslverr, prdata
  );
endinterface

// File: rtl/apb_gpio_chan_mux.sv
// Selects the addressed channel's ack and read data from the flattened core buses.
module apb_gpio_chan_mux #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CH_W   = 2
) (
  input  logic [CH_W-1:0]          sel,
  input  logic [NUM_CH-1:0]        ack,
  input  logic [NUM_CH*DATA_W-1:0] dat,
  output logic                     ack_c,
  output logic [DATA_W-1:0]        dat_c
);

  always_comb begin
    ack_c = 1'b0;
    dat_c = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (sel == CH_W'(k)) begin
        ack_c = ack[k];
        dat_c = dat[k*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/apb_gpio_bridge_mc.sv
// APB3 slave routing each transfer to one of NUM_CH GPIO cores with stb/ack
// wait states, timeout, error response and registered interrupt aggregation.
module apb_gpio_bridge_mc
  import apb_gpio_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned CH_LSB  = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                     pclk,
  input  logic                     presetn,
  apb_gpio_bridge_mc_if.slave      apb,
  output logic [NUM_CH-1:0]        gpio_stb,
  output logic                     gpio_we,
  output logic [CH_LSB-1:0]        gpio_addr,
  output logic [DATA_W-1:0]        gpio_dat_i,
  input  logic [NUM_CH-1:0]        gpio_ack,
  input  logic [NUM_CH*DATA_W-1:0] gpio_dat_o,
  input  logic [NUM_CH-1:0]        gpio_inta,
  output logic [NUM_CH-1:0]        irq_vec,
  output logic                     irq
);

  localparam int unsigned CH_W  = ch_w(NUM_CH);
  localparam int unsigned TO_W  = to_w(TIMEOUT);
  localparam int unsigned CHR_W = ADDR_W - CH_LSB;

  state_e              state_q, state_d;
  logic [TO_W-1:0]     cnt_q, cnt_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [NUM_CH-1:0]   stb_d;
  logic                we_d;
  logic [CH_LSB-1:0]   addr_d;
  logic [DATA_W-1:0]   wdat_d;
  logic                pready_q, pready_d;
  logic                pslverr_q, pslverr_d;
  logic [DATA_W-1:0]   prdata_q, prdata_d;
  logic [CHR_W-1:0]    ch_raw;
  logic                ch_ok;
  logic                setup;
  logic                sel_ack_c;
  logic [DATA_W-1:0]   sel_dat_c;

  assign ch_raw = apb.paddr[ADDR_W-1:CH_LSB];
  assign ch_ok  = 32'(ch_raw) < NUM_CH;
  assign setup  = apb.psel && !apb.penable;

  assign apb.pready  = pready_q;
  assign apb.pslverr = pslverr_q;
  assign apb.prdata  = prdata_q;

  apb_gpio_chan_mux #(
    .DATA_W (DATA_W),
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_mux (
    .sel   (ch_q),
    .ack   (gpio_ack),
    .dat   (gpio_dat_o),
    .ack_c (sel_ack_c),
    .dat_c (sel_dat_c)
  );

  // State, counter and all registered outputs.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ch_q       <= '0;
      gpio_stb   <= '0;
      gpio_we    <= 1'b0;
      gpio_addr  <= '0;
      gpio_dat_i <= '0;
      pready_q   <= 1'b0;
      pslverr_q  <= 1'b0;
      prdata_q   <= '0;
      irq_vec    <= '0;
      irq        <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ch_q       <= ch_d;
      gpio_stb   <= stb_d;
      gpio_we    <= we_d;
      gpio_addr  <= addr_d;
      gpio_dat_i <= wdat_d;
      pready_q   <= pready_d;
      pslverr_q  <= pslverr_d;
      prdata_q   <= prdata_d;
      irq_vec    <= gpio_inta;
      irq        <= |gpio_inta;
    end
  end

  // Next-state and next-output logic; pready/pslverr are set only on entry to RESP.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ch_d      = ch_q;
    stb_d     = gpio_stb;
    we_d      = gpio_we;
    addr_d    = gpio_addr;
    wdat_d    = gpio_dat_i;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = prdata_q;

    case (state_q)
      IDLE: begin
        if (setup) begin
          we_d   = apb.pwrite;
          addr_d = apb.paddr[CH_LSB-1:0];
          wdat_d = apb.pwdata;
          cnt_d  = '0;
          if (ch_ok) begin
            ch_d    = CH_W'(ch_raw);
            stb_d   = NUM_CH'(1) << ch_raw;
            state_d = WAIT;
          end else begin
            state_d   = RESP;
            pready_d  = 1'b1;
            pslverr_d = 1'b1;
            if (!apb.pwrite) prdata_d = '0;
          end
        end
      end

      WAIT: begin
        if (!apb.psel) begin
          state_d = IDLE;
          stb_d   = '0;
          cnt_d   = '0;
        end else if (sel_ack_c) begin
          state_d  = RESP;
          stb_d    = '0;
          pready_d = 1'b1;
          if (!gpio_we) prdata_d = sel_dat_c;
        end else if (cnt_q == TO_W'(TIMEOUT - 1)) begin
          state_d   = RESP;
          stb_d     = '0;
          pready_d  = 1'b1;
          pslverr_d = 1'b1;
          if (!gpio_we) prdata_d = '0;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end

      RESP: begin
        state_d = IDLE;
        cnt_d   = '0;
      end

      default: begin
        state_d = IDLE;
        stb_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_apb_gpio_bridge_mc.sv
// Directed self-checking bench for apb_gpio_bridge_mc (default parameters).
module tb_apb_gpio_bridge_mc;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned NUM_CH  = 4;
  localparam int unsigned CH_LSB  = 8;
  localparam int unsigned TIMEOUT = 16;

  logic                     pclk;
  logic                     presetn;
  logic [NUM_CH-1:0]        gpio_stb;
  logic                     gpio_we;
  logic [CH_LSB-1:0]        gpio_addr;
  logic [DATA_W-1:0]        gpio_dat_i;
  logic [NUM_CH-1:0]        gpio_ack;
  logic [NUM_CH*DATA_W-1:0] gpio_dat_o;
  logic [NUM_CH-1:0]        gpio_inta;
  logic [NUM_CH-1:0]        irq_vec;
  logic                     irq;

  int n_checks = 0;
  int n_fail   = 0;

  apb_gpio_bridge_mc_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  apb_gpio_bridge_mc #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .NUM_CH  (NUM_CH),
    .CH_LSB  (CH_LSB),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .pclk       (pclk),
    .presetn    (presetn),
    .apb        (bus.slave),
    .gpio_stb   (gpio_stb),
    .gpio_we    (gpio_we),
    .gpio_addr  (gpio_addr),
    .gpio_dat_i (gpio_dat_i),
    .gpio_ack   (gpio_ack),
    .gpio_dat_o (gpio_dat_o),
    .gpio_inta  (gpio_inta),
    .irq_vec    (irq_vec),
    .irq        (irq)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge; outputs are sampled and inputs driven there.
  task automatic step();
    @(negedge pclk);
  endtask

  task automatic setup_phase(input logic wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.psel    = 1'b1;
    bus.penable = 1'b0;
    bus.pwrite  = wr;
    bus.paddr   = a;
    bus.pwdata  = d;
  endtask

  task automatic bus_idle();
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    gpio_ack    = '0;
  endtask

  initial begin
    presetn     = 1'b0;
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b0;
    bus.paddr   = '0;
    bus.pwdata  = '0;
    gpio_ack    = '0;
    gpio_dat_o  = '0;
    gpio_inta   = '0;
    step();
    step();

    // Reset state
    chk("rst_pready",  64'(bus.pready), 64'd0);
    chk("rst_pslverr", 64'(bus.pslverr), 64'd0);
    chk("rst_prdata",  64'(bus.prdata), 64'd0);
    chk("rst_stb",     64'(gpio_stb), 64'd0);
    chk("rst_we",      64'(gpio_we), 64'd0);
    chk("rst_addr",    64'(gpio_addr), 64'd0);
    chk("rst_dat_i",   64'(gpio_dat_i), 64'd0);
    chk("rst_irq_vec", 64'(irq_vec), 64'd0);
    chk("rst_irq",     64'(irq), 64'd0);
    presetn = 1'b1;
    step();

    // Write ch1, ack in first WAIT cycle -> pready in 3rd cycle
    setup_phase(1'b1, 16'h0104, 32'hA5A5_0001);
    step();
    chk("wr_stb",    64'(gpio_stb), 64'h2);
    chk("wr_addr",   64'(gpio_addr), 64'h04);
    chk("wr_we",     64'(gpio_we), 64'd1);
    chk("wr_dat_i",  64'(gpio_dat_i), 64'hA5A5_0001);
    chk("wr_rdy_c2", 64'(bus.pready), 64'd0);
    bus.penable = 1'b1;
    gpio_ack    = 4'b0010;
    step();
    chk("wr_rdy_c3", 64'(bus.pready), 64'd1);
    chk("wr_err_c3", 64'(bus.pslverr), 64'd0);
    chk("wr_stb_c3", 64'(gpio_stb), 64'd0);
    bus_idle();
    step();
    chk("wr_rdy_end",  64'(bus.pready), 64'd0);
    chk("wr_prdata_h", 64'(bus.prdata), 64'd0);

    // Read ch3, ack after 5 WAIT cycles; ack on ch1 meanwhile must be ignored
    gpio_dat_o[1*DATA_W +: DATA_W] = 32'h1111_1111;
    gpio_dat_o[3*DATA_W +: DATA_W] = 32'hDEAD_BEEF;
    setup_phase(1'b0, 16'h0308, 32'h0);
    step();
    bus.penable = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      chk($sformatf("rd_stb_w%0d", i), 64'(gpio_stb), 64'h8);
      chk($sformatf("rd_rdy_w%0d", i), 64'(bus.pready), 64'd0);
      gpio_ack = (i == 5) ? 4'b1000 : 4'b0010;
      step();
    end
    chk("rd_rdy",    64'(bus.pready), 64'd1);
    chk("rd_err",    64'(bus.pslverr), 64'd0);
    chk("rd_prdata", 64'(bus.prdata), 64'hDEAD_BEEF);
    bus_idle();
    step();
    chk("rd_rdy_end",  64'(bus.pready), 64'd0);
    chk("rd_prdata_h", 64'(bus.prdata), 64'hDEAD_BEEF);

    // Bad decode ch5 -> error in 2nd cycle, no strobe
    setup_phase(1'b0, 16'h0500, 32'h0);
    step();
    chk("bad_stb",    64'(gpio_stb), 64'd0);
    chk("bad_rdy",    64'(bus.pready), 64'd1);
    chk("bad_err",    64'(bus.pslverr), 64'd1);
    chk("bad_prdata", 64'(bus.prdata), 64'd0);
    bus_idle();
    step();
    chk("bad_rdy_end", 64'(bus.pready), 64'd0);
    chk("bad_err_end", 64'(bus.pslverr), 64'd0);

    // Timeout on ch2: pready in cycle TIMEOUT+2 = 18
    gpio_dat_o[2*DATA_W +: DATA_W] = 32'h1234_5678;
    setup_phase(1'b0, 16'h0200, 32'h0);
    step();
    bus.penable = 1'b1;
    for (int c = 2; c <= 17; c++) begin
      if (c == 2 || c == 17) begin
        chk($sformatf("to_rdy_c%0d", c), 64'(bus.pready), 64'd0);
        chk($sformatf("to_stb_c%0d", c), 64'(gpio_stb), 64'h4);
      end
      step();
    end
    chk("to_rdy_c18", 64'(bus.pready), 64'd1);
    chk("to_err_c18", 64'(bus.pslverr), 64'd1);
    chk("to_prdata",  64'(bus.prdata), 64'd0);
    bus_idle();
    step();

    // Ack exactly at count 15 wins over timeout
    setup_phase(1'b0, 16'h0210, 32'h0);
    step();
    bus.penable = 1'b1;
    for (int c = 2; c <= 17; c++) begin
      if (c == 17) gpio_ack = 4'b0100;
      step();
    end
    chk("ack15_rdy",    64'(bus.pready), 64'd1);
    chk("ack15_err",    64'(bus.pslverr), 64'd0);
    chk("ack15_prdata", 64'(bus.prdata), 64'h1234_5678);
    bus_idle();
    step();

    // psel dropped in WAIT: strobe removed, no response
    setup_phase(1'b0, 16'h0100, 32'h0);
    step();
    chk("drop_stb_w", 64'(gpio_stb), 64'h2);
    bus_idle();
    step();
    chk("drop_stb", 64'(gpio_stb), 64'd0);
    chk("drop_rdy", 64'(bus.pready), 64'd0);
    step();
    chk("drop_rdy2", 64'(bus.pready), 64'd0);

    // Interrupt aggregation, one cycle latency
    gpio_inta = 4'b0100;
    chk("irq_pre", 64'(irq), 64'd0);
    step();
    chk("irq_vec_set", 64'(irq_vec), 64'h4);
    chk("irq_set",     64'(irq), 64'd1);
    gpio_inta = 4'b0000;
    step();
    chk("irq_vec_clr", 64'(irq_vec), 64'd0);
    chk("irq_clr",     64'(irq), 64'd0);

    // Asynchronous reset during WAIT
    setup_phase(1'b1, 16'h0004, 32'hCAFE_0000);
    step();
    chk("ar_stb_pre", 64'(gpio_stb), 64'h1);
    bus.penable = 1'b1;
    #2;
    presetn = 1'b0;
    #1;
    chk("ar_stb",    64'(gpio_stb), 64'd0);
    chk("ar_rdy",    64'(bus.pready), 64'd0);
    chk("ar_prdata", 64'(bus.prdata), 64'd0);
    bus_idle();
    step();
    presetn = 1'b1;
    step();
    setup_phase(1'b1, 16'h0010, 32'h0BAD_F00D);
    step();
    chk("ar2_stb",  64'(gpio_stb), 64'h1);
    chk("ar2_addr", 64'(gpio_addr), 64'h10);
    bus.penable = 1'b1;
    gpio_ack    = 4'b0001;
    step();
    chk("ar2_rdy", 64'(bus.pready), 64'd1);
    chk("ar2_err", 64'(bus.pslverr), 64'd0);
    bus_idle();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_gpio_bridge_mc.md
Name: apb_gpio_bridge_mc

Overview:
- Parametrised successor to the single-core APB-to-GPIO slave interface.
- Terminates an APB3 slave port and routes each transfer to one of NUM_CH GPIO cores, selected by address.
- Adds downstream wait-state handshake (stb/ack), a timeout, PSLVERR for bad decode or timeout, registered read data, and per-channel interrupt aggregation.
- Sits between the system APB fabric and the GPIO core array.

Parameters:
- DATA_W, 32, APB and GPIO data width.
- ADDR_W, 16, APB address width.
- NUM_CH, 4, number of downstream GPIO cores (1..16).
- CH_LSB, 8, lowest paddr bit of the channel index; paddr[CH_LSB-1:0] is the register offset.
- TIMEOUT, 16, maximum cycles in WAIT before an error response (2..255).

Ports:
- pclk  in  1  clock, all logic on the rising edge.
- presetn  in  1  asynchronous active-low reset.
- psel  in  1  APB select.
- penable  in  1  APB enable.
- pwrite  in  1  1=write, 0=read.
- paddr  in  ADDR_W  APB address.
- pwdata  in  DATA_W  APB write data.
- pready  out  1  transfer complete.
- pslverr  out  1  error response, valid only while pready=1.
- prdata  out  DATA_W  registered read data.
- gpio_stb  out  NUM_CH  one-hot request strobe to the selected core.
- gpio_we  out  1  write enable, broadcast.
- gpio_addr  out  CH_LSB  register offset, broadcast.
- gpio_dat_i  out  DATA_W  write data, broadcast.
- gpio_ack  in  NUM_CH  per-core completion.
- gpio_dat_o  in  NUM_CH*DATA_W  per-core read data, flattened; channel k at [k*DATA_W +: DATA_W].
- gpio_inta  in  NUM_CH  per-core interrupt, level.
- irq_vec  out  NUM_CH  gpio_inta registered once.
- irq  out  1  OR of irq_vec.

Behaviour:
- Reset (presetn=0, async): state=IDLE.
  - pready=0, pslverr=0, prdata=0.
  - gpio_stb=0, gpio_we=0, gpio_addr=0, gpio_dat_i=0.
  - irq_vec=0, irq=0, timeout counter=0.
  - Reset mid-transfer aborts it immediately; no stb or pready may glitch out.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - On psel=1 and penable=0 (setup phase), register paddr, pwrite and pwdata.
  - ch = paddr[ADDR_W-1:CH_LSB].
  - If ch < NUM_CH: go to WAIT, and assert gpio_stb[ch], gpio_we, gpio_addr and gpio_dat_i from the next cycle.
  - If ch >= NUM_CH: go to RESP with error; no strobe is issued.
- WAIT:
  - gpio_stb[ch], gpio_we, gpio_addr and gpio_dat_i are held stable; the counter increments each cycle.
  - gpio_ack[ch]=1: go to RESP. For a read, capture gpio_dat_o slice ch into prdata. pslverr=0.
  - No ack and counter = TIMEOUT-1: go to RESP with pslverr=1 and prdata=0.
  - If ack and timeout occur in the same cycle, ack wins.
  - gpio_ack on non-selected channels is ignored.
  - psel=0 in WAIT (master protocol violation): drop the strobe and return to IDLE with no response.
- RESP:
  - pready=1 for exactly one cycle, with pslverr as decided; gpio_stb=0.
  - Always returns to IDLE. The next setup phase coincides with the first IDLE cycle, so back-to-back transfers carry no bubble.
- Latency from setup cycle to pready:
  - Good channel, ack in first WAIT cycle: pready in the 3rd cycle (one APB wait state).
  - Bad decode: pready in the 2nd cycle (zero wait states).
  - Timeout: pready in cycle TIMEOUT+2.
- pready=0 in IDLE and WAIT. pslverr=0 whenever pready=0.
- prdata changes only on read completion (data or 0 on error); it holds across writes and idle cycles.
- gpio_stb is one-hot or zero, never multi-hot.
- irq_vec <= gpio_inta every cycle; irq = |irq_vec, registered. Total interrupt latency is 1 cycle.

Decomposition:
- Package apb_gpio_pkg holds:
  - state enum (IDLE, WAIT, RESP);
  - CH_W = clog2(NUM_CH) helper;
  - TO_W = clog2(TIMEOUT) helper.
- One natural sub-module: apb_gpio_chan_mux (ch-indexed read-data and ack select from the flattened buses).
- FSM, counter and irq registers stay in the top.

Test Plan:
- Reset during WAIT with stb asserted -> stb=0, pready=0 and prdata=0 immediately (asynchronously); after release, the next write completes normally.
- Write paddr=0x0104, pwdata=0xA5A5_0001, ack on ch1 in the first WAIT cycle -> gpio_stb=4'b0010, gpio_addr=0x04, gpio_we=1; pready=1 and pslverr=0 in the 3rd cycle.
- Read paddr=0x0308, ch3 acks after 5 WAIT cycles with dat_o=0xDEAD_BEEF -> prdata=0xDEADBEEF with pready in the same cycle; stb held stable for all 5 cycles.
- Read paddr=0x0500 (ch5 >= NUM_CH) -> no stb; pready=1, pslverr=1 and prdata=0 in the 2nd cycle.
- Read ch2 with no ack -> pready=1 and pslverr=1 in cycle 18 (TIMEOUT=16); ack arriving exactly at count 15 instead -> pslverr=0.
- gpio_inta=4'b0100 asserted -> irq_vec=4'b0100 and irq=1 one cycle later; deassert -> irq=0 one cycle later.
